// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-owner codes and starvation counter width.
package dmem_arbiter_pkg;

    // Width of the starvation counter; wide enough for a burst limit of 15.
    localparam int unsigned STARVE_CNT_BITS = 4;

    // Owner tag stored with a pending read so the response is steered to the right port.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_owner_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive CPU grants taken while the debug port is waiting; flags when the limit is hit.
module dmem_arbiter_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_CNT_BITS-1:0] MaxCnt = STARVE_CNT_BITS'(MAX_CPU_BURST);

    logic [STARVE_CNT_BITS-1:0] cnt_q;
    logic [STARVE_CNT_BITS-1:0] cnt_d;

    // Next count: clear wins over increment, increment saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Debug is forced through once the CPU has used up its burst allowance.
    always_comb begin
        at_max = (cnt_q == MaxCnt);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU and debug ports, with CPU priority
// bounded by a starvation limit, and steers one-cycle-latency read data back to its owner.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = 11,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned MAX_CPU_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    // CPU port
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_BIT_WIDTH-1:0] cpu_addr,
    input  logic [DATA_BIT_WIDTH-1:0] cpu_wdata,
    output logic                      cpu_gnt,
    output logic                      cpu_rvalid,
    output logic [DATA_BIT_WIDTH-1:0] cpu_rdata,
    // Debug/loader port
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [ADDR_BIT_WIDTH-1:0] dbg_addr,
    input  logic [DATA_BIT_WIDTH-1:0] dbg_wdata,
    output logic                      dbg_gnt,
    output logic                      dbg_rvalid,
    output logic [DATA_BIT_WIDTH-1:0] dbg_rdata,
    // Memory port
    output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
    output logic                      mem_we,
    output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BIT_WIDTH-1:0] mem_rdata
);

    logic       starve_at_max;
    logic       starve_inc;
    logic       starve_clr;
    logic       rd_pend_q;
    logic       rd_pend_d;
    req_owner_e rd_owner_q;
    req_owner_e rd_owner_d;

    dmem_arbiter_starve_counter #(
        .MAX_CPU_BURST(MAX_CPU_BURST)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .at_max(starve_at_max)
    );

    // Grant decision: CPU wins contention unless debug has waited out the burst limit.
    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (reset) begin
            if (cpu_req && dbg_req) begin
                dbg_gnt = starve_at_max;
                cpu_gnt = !starve_at_max;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    // Starvation ageing only happens while debug is actually waiting; idle cycles reset it.
    always_comb begin
        starve_inc = cpu_gnt && dbg_req;
        starve_clr = dbg_gnt || !dbg_req;
    end

    // Memory request mux from the granted port; bus is parked at zero when nobody is granted.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_we    = dbg_we;
            mem_wdata = dbg_wdata;
        end
    end

    // Next read-tracking state: a granted read arms the response for the following cycle.
    always_comb begin
        rd_pend_d  = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = dbg_gnt ? REQ_DBG : REQ_CPU;
        end
    end

    // Read-tracking registers; async reset drops any in-flight response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Response steering: only the owner sees valid data, the other port reads zero.
    always_comb begin
        cpu_rvalid = rd_pend_q && (rd_owner_q == REQ_CPU);
        dbg_rvalid = rd_pend_q && (rd_owner_q == REQ_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (burst limit 4 and 1) share one stimulus stream;
// a behavioural model checks every output each cycle, plus literal checks pin key scenarios.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [10:0] cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;

    logic [1:0]  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
    logic [31:0] cpu_rdata [2];
    logic [31:0] dbg_rdata [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [10:0] mem_addr  [2];

    logic [31:0] mem_arr [2][2048];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_BIT_WIDTH(11), .DATA_BIT_WIDTH(32), .MAX_CPU_BURST(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_rdata(dbg_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.ADDR_BIT_WIDTH(11), .DATA_BIT_WIDTH(32), .MAX_CPU_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_rdata(dbg_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    // Synchronous single-port memory behind each arbiter, one cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) mem_arr[k][mem_addr[k]] <= mem_wdata[k];
            mem_rdata[k] <= mem_arr[k][mem_addr[k]];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          max_burst [2] = '{4, 1};
    int          run       [2];   // CPU grants in a row while debug has been waiting
    bit          pend      [2];
    bit          pown      [2];   // 1 = debug owns the pending read
    logic [31:0] pdata     [2];
    logic [31:0] shadow    [2][2048];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        eg_c, eg_d, e_cv, e_dv, e_we;
            logic [10:0] e_addr;
            logic [31:0] e_wd, e_crd, e_drd;
            eg_c = 0; eg_d = 0; e_cv = 0; e_dv = 0;
            if (!reset) begin
                run[k]  = 0;
                pend[k] = 0;
            end else begin
                e_cv = pend[k] && !pown[k];
                e_dv = pend[k] && pown[k];
                if (cpu_req && dbg_req) begin
                    eg_d = (run[k] >= max_burst[k]);
                    eg_c = !eg_d;
                end else begin
                    eg_c = cpu_req;
                    eg_d = dbg_req;
                end
            end
            e_crd = e_cv ? pdata[k] : 32'h0;
            e_drd = e_dv ? pdata[k] : 32'h0;
            e_addr = eg_c ? cpu_addr : (eg_d ? dbg_addr : 11'h0);
            e_we   = eg_c ? cpu_we : (eg_d ? dbg_we : 1'b0);
            e_wd   = eg_c ? cpu_wdata : (eg_d ? dbg_wdata : 32'h0);

            chk($sformatf("m%0d.cpu_gnt", k), {31'h0, cpu_gnt[k]}, {31'h0, eg_c});
            chk($sformatf("m%0d.dbg_gnt", k), {31'h0, dbg_gnt[k]}, {31'h0, eg_d});
            chk($sformatf("m%0d.cpu_rvalid", k), {31'h0, cpu_rvalid[k]}, {31'h0, e_cv});
            chk($sformatf("m%0d.dbg_rvalid", k), {31'h0, dbg_rvalid[k]}, {31'h0, e_dv});
            chk($sformatf("m%0d.cpu_rdata", k), cpu_rdata[k], e_crd);
            chk($sformatf("m%0d.dbg_rdata", k), dbg_rdata[k], e_drd);
            chk($sformatf("m%0d.mem_addr", k), {21'h0, mem_addr[k]}, {21'h0, e_addr});
            chk($sformatf("m%0d.mem_we", k), {31'h0, mem_we[k]}, {31'h0, e_we});
            chk($sformatf("m%0d.mem_wdata", k), mem_wdata[k], e_wd);

            if (reset) begin
                if (eg_c && dbg_req) run[k] = run[k] + 1;
                else if (eg_d || !dbg_req) run[k] = 0;
                pend[k] = (eg_c || eg_d) && !e_we;
                if (pend[k]) begin
                    pown[k]  = eg_d;
                    pdata[k] = shadow[k][e_addr];
                end
                if ((eg_c || eg_d) && e_we) shadow[k][e_addr] = e_wd;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] pat [2];
    int         ncpu [2];
    int         nrv_c [2];
    int         nrv_d [2];
    bit         seen [2];

    initial begin
        reset = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h005; cpu_wdata = 32'h1234_5678;
        dbg_req = 1; dbg_we = 1; dbg_addr = 11'h006; dbg_wdata = 32'h8765_4321;

        // 1: requests under reset are ignored
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t1.cpu_gnt_rst%0d", k), {31'h0, cpu_gnt[k]}, 32'h0);
            chk($sformatf("t1.dbg_gnt_rst%0d", k), {31'h0, dbg_gnt[k]}, 32'h0);
        end
        next_cycle();
        cpu_req = 0; dbg_req = 0; reset = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t1.mem_we_idle%0d", k), {31'h0, mem_we[k]}, 32'h0);
            chk($sformatf("t1.mem_addr_idle%0d", k), {21'h0, mem_addr[k]}, 32'h0);
        end

        // 2: CPU alone, write then read back
        next_cycle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h010; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("t2.wr_gnt%0d", k), {31'h0, cpu_gnt[k]}, 32'h1);
        next_cycle();
        cpu_we = 0;
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t2.rvalid%0d", k), {31'h0, cpu_rvalid[k]}, 32'h1);
            chk($sformatf("t2.rdata%0d", k), cpu_rdata[k], 32'hDEAD_BEEF);
        end

        // 3: continuous contention, grant pattern per burst limit
        next_cycle();
        cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 11'h010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[0][i] = dbg_gnt[0];
            pat[1][i] = dbg_gnt[1];
            next_cycle();
        end
        cpu_req = 0; dbg_req = 0;
        chk("t3.dbg_pattern_max4", {22'h0, pat[0]}, 32'h210);
        chk("t3.dbg_pattern_max1", {22'h0, pat[1]}, 32'h2AA);

        // 4: preload via debug, then alternating contended reads
        next_cycle();
        dbg_req = 1; dbg_we = 1; dbg_addr = 11'h001; dbg_wdata = 32'h11;
        next_cycle();
        dbg_addr = 11'h002; dbg_wdata = 32'h22;
        next_cycle();
        dbg_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001;
        for (int k = 0; k < 2; k++) begin nrv_c[k] = 0; nrv_d[k] = 0; end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cpu_rvalid[k]) begin
                    nrv_c[k]++;
                    chk($sformatf("t4.cpu_rdata%0d", k), cpu_rdata[k], 32'h11);
                end
                if (dbg_rvalid[k]) begin
                    nrv_d[k]++;
                    chk($sformatf("t4.dbg_rdata%0d", k), dbg_rdata[k], 32'h22);
                end
            end
            next_cycle();
            if (i == 5) begin cpu_req = 0; dbg_req = 0; end
        end
        chk("t4.cpu_reads_max4", nrv_c[0], 32'd5);
        chk("t4.dbg_reads_max4", nrv_d[0], 32'd1);
        chk("t4.cpu_reads_max1", nrv_c[1], 32'd3);
        chk("t4.dbg_reads_max1", nrv_d[1], 32'd3);

        // 5: reset during a pending debug read
        dbg_req = 1; dbg_we = 0; dbg_addr = 11'h002;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("t5.dbg_gnt%0d", k), {31'h0, dbg_gnt[k]}, 32'h1);
        next_cycle();
        dbg_req = 0; reset = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("t5.rv_in_rst%0d", k), {31'h0, dbg_rvalid[k]}, 32'h0);
        next_cycle();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk($sformatf("t5.rv_after%0d", k), {30'h0, dbg_rvalid[k], cpu_rvalid[k]}, 32'h0);
            next_cycle();
        end

        // 6: debug withdraws mid-contention, counter must restart
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001; dbg_req = 1; dbg_we = 0; dbg_addr = 11'h002;
        @(negedge clk);
        chk("t6.first_cpu", {31'h0, cpu_gnt[0]}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("t6.second_cpu", {31'h0, cpu_gnt[0]}, 32'h1);
        next_cycle();
        dbg_req = 0;
        next_cycle();
        dbg_req = 1;
        for (int k = 0; k < 2; k++) begin ncpu[k] = 0; seen[k] = 0; end
        for (int i = 0; i < 20 && !(seen[0] && seen[1]); i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!seen[k]) begin
                    if (dbg_gnt[k]) seen[k] = 1;
                    else if (cpu_gnt[k]) ncpu[k]++;
                end
            end
            next_cycle();
        end
        chk("t6.dbg_seen_max4", {31'h0, seen[0]}, 32'h1);
        chk("t6.dbg_seen_max1", {31'h0, seen[1]}, 32'h1);
        chk("t6.cpu_before_dbg_max4", ncpu[0], 32'd4);
        chk("t6.cpu_before_dbg_max1", ncpu[1], 32'd1);
        cpu_req = 0; dbg_req = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
